msrv32_fetch_buffer: RTL and testbench

//  Instruction fetch stage: owns the fetch PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.

---
 rtl/msrv32_fetch_buffer.sv | 178 +++++++++++++++++
 tb/tb_msrv32_fetch_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/msrv32_fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests and buffers returned words with their PCs.
// Optional macro MSRV32_FETCH_PERF_EN adds a saturating fetch-bubble counter output.
module msrv32_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out
`ifdef MSRV32_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_bubble_cnt_out
`endif
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, last_pc_q, last_pc_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   word_d [DEPTH];
  logic [31:0]   tag_q  [DEPTH];
  logic [31:0]   tag_d  [DEPTH];
  logic          req_en_q, req_en_d;
  logic [CW:0]   occupancy_s;
  logic          valid_s, grant_s, rsp_s, push_s, pop_s;
  logic          unused_s;

  assign unused_s = ^redirect_pc_in[1:0];

  // Handshake decode and output view of the FIFO head.
  always_comb begin
    valid_s         = (count_q != {CW{1'b0}});
    occupancy_s     = {1'b0, outst_q} + {1'b0, count_q};
    imem_req_out    = ms_riscv32_mp_rst_in & req_en_q & ~redirect_in &
                      (occupancy_s < (CW+1)'(DEPTH));
    imem_addr_out   = fetch_pc_q;
    grant_s         = imem_req_out & imem_gnt_in;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_s           = imem_rvalid_in & (outst_q != {CW{1'b0}});
    push_s          = rsp_s & (drop_q == {CW{1'b0}}) & ~redirect_in;
    pop_s           = valid_s & ~stall_in;
    instr_valid_out = valid_s;
    flush_out       = ~valid_s;
    if (valid_s) begin
      instr_out = word_q[rd_ptr_q];
      pc_out    = tag_q[rd_ptr_q];
    end else begin
      instr_out = NOP;
      pc_out    = last_pc_q;
    end
  end

  // Next-state logic; a redirect overrides every other event of the cycle.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    last_pc_d  = last_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    word_d     = word_q;
    tag_d      = tag_q;
    req_en_d   = 1'b1;
    outst_d    = outst_q + CW'(grant_s) - CW'(rsp_s);
    if (pop_s) begin
      last_pc_d = tag_q[rd_ptr_q];
    end else begin
      last_pc_d = last_pc_q;
    end
    if (redirect_in) begin
      fetch_pc_d = {redirect_pc_in[31:2], 2'b00};
      resp_pc_d  = {redirect_pc_in[31:2], 2'b00};
      count_d    = {CW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      wr_ptr_d   = {AW{1'b0}};
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d     = outst_d;
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rsp_s && (drop_q != {CW{1'b0}})) begin
        drop_d = drop_q - CW'(1'b1);
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        word_d[wr_ptr_q] = imem_rdata_in;
        tag_d[wr_ptr_q]  = resp_pc_q;
        wr_ptr_d         = wr_ptr_q + AW'(1'b1);
        resp_pc_d        = resp_pc_q + 32'd4;
      end else begin
        wr_ptr_d  = wr_ptr_q;
        resp_pc_d = resp_pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      last_pc_q  <= RESET_PC;
      count_q    <= {CW{1'b0}};
      outst_q    <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      req_en_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      last_pc_q  <= last_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      req_en_q   <= req_en_d;
    end
  end

  // FIFO payload storage; entries are only read while counted as valid.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    word_q <= word_d;
    tag_q  <= tag_d;
  end

`ifdef MSRV32_FETCH_PERF_EN
  logic [31:0] bubble_q, bubble_d;

  // Counts cycles where the decoder is ready but nothing is buffered.
  always_comb begin
    if (~valid_s && ~stall_in && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_d = bubble_q + 32'd1;
    end else begin
      bubble_d = bubble_q;
    end
  end

  // Bubble counter register.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      bubble_q <= 32'd0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign fetch_bubble_cnt_out = bubble_q;
`endif

endmodule

// File: tb/tb_msrv32_fetch_buffer.sv
// Scoreboard bench for msrv32_fetch_buffer: the bench plays instruction memory and predicts the fetch stream.
module tb_msrv32_fetch_buffer;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n, req, gnt, rvalid, redirect, stall, valid, flush;
  logic [31:0] addr, rdata, redirect_pc, instr, pc;
`ifdef MSRV32_FETCH_PERF_EN
  logic [31:0] bubble;
`endif

  always #5 clk = ~clk;

  msrv32_fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .imem_req_out(req),
    .imem_addr_out(addr),
    .imem_gnt_in(gnt),
    .imem_rvalid_in(rvalid),
    .imem_rdata_in(rdata),
    .redirect_in(redirect),
    .redirect_pc_in(redirect_pc),
    .stall_in(stall),
    .instr_out(instr),
    .pc_out(pc),
    .instr_valid_out(valid),
    .flush_out(flush)
`ifdef MSRV32_FETCH_PERF_EN
    ,
    .fetch_bubble_cnt_out(bubble)
`endif
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] epoch; } mem_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;

  mem_t        mem_q[$];  // granted requests awaiting a response, in order
  exp_t        exp_q[$];  // words the fetch buffer should be holding, in order
  logic [31:0] model_fetch_pc = RESET_PC;
  logic [31:0] epoch = 32'd0;
  logic [31:0] last_pc = RESET_PC;
  logic [31:0] bubble_exp = 32'd0;
  bit          req_block, armed, cyc_valid, done, done_chk, spurious_en;
  int          n_checks, n_fail, miss_cnt;

  function automatic logic [31:0] b32(input bit x);
    return {31'd0, x};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard and pops consumed words.
  always @(negedge clk) begin
    bit exp_req;
    if (armed) begin
      cyc_valid = (exp_q.size() != 0);
      exp_req   = rst_n && !req_block && !redirect && ((mem_q.size() + exp_q.size()) < DEPTH);
      chk("instr_valid", b32(valid), b32(cyc_valid));
      chk("flush", b32(flush), b32(!cyc_valid));
      chk("req", b32(req), b32(exp_req));
      if (req) chk("addr", addr, model_fetch_pc);
      if (cyc_valid) begin
        chk("instr", instr, exp_q[0].word);
        chk("pc", pc, exp_q[0].pc);
        if (!stall) begin
          last_pc = exp_q[0].pc;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("instr_nop", instr, NOP);
        chk("pc_idle", pc, last_pc);
      end
`ifdef MSRV32_FETCH_PERF_EN
      chk("bubble_cnt", bubble, bubble_exp);
`endif
      if (!rst_n) last_pc = RESET_PC;
      if (done && !done_chk) begin
        chk("setup_bounds", miss_cnt, 32'd0);
        done_chk = 1'b1;
      end
    end
  end

  // Reference model: tracks the imem protocol and pushes the words that should survive.
  always @(negedge clk) begin
    mem_t e;
    #1;
    if (!rst_n) begin
      mem_q.delete();
      exp_q.delete();
      model_fetch_pc = RESET_PC;
      req_block      = 1'b1;
      epoch          = epoch + 32'd1;
      bubble_exp     = 32'd0;
      armed          = 1'b1;
    end else if (armed) begin
      req_block = 1'b0;
      if (rvalid && mem_q.size() != 0) begin
        e = mem_q.pop_front();
        if (!redirect && e.epoch == epoch) exp_q.push_back('{pc: e.pc, word: e.pc ^ KEY});
      end
      if (req && gnt) begin
        mem_q.push_back('{pc: model_fetch_pc, epoch: epoch});
        model_fetch_pc = model_fetch_pc + 32'd4;
      end
      if (redirect) begin
        exp_q.delete();
        epoch          = epoch + 32'd1;
        model_fetch_pc = {redirect_pc[31:2], 2'b00};
      end
      if (!cyc_valid && !stall && bubble_exp != 32'hFFFF_FFFF) bubble_exp = bubble_exp + 32'd1;
    end
  end

  // rd_mode: 0 none, 1 redirect, 2 redirect when FIFO and imem both busy, 3 redirect when 2 in flight.
  task automatic step(input bit g, input bit rv_en, input bit st, input int rd_mode,
                      input logic [31:0] tgt, input bit rs, output bit fired);
    @(posedge clk);
    #1;
    fired = (rd_mode == 1) ||
            (rd_mode == 2 && exp_q.size() != 0 && mem_q.size() != 0) ||
            (rd_mode == 3 && mem_q.size() == 2);
    fired       = fired && rs;
    rst_n       = rs;
    gnt         = g;
    stall       = (rd_mode == 2 && fired) ? 1'b0 : st;
    redirect    = fired;
    redirect_pc = tgt;
    if (rs && rv_en && mem_q.size() != 0) begin
      rvalid = 1'b1;
      rdata  = mem_q[0].pc ^ KEY;
    end else begin
      rvalid = rs && spurious_en && mem_q.size() == 0 && ($urandom_range(0, 19) == 0);
      rdata  = $urandom;
    end
  endtask

  initial begin
    bit f, hit;
    rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    redirect = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0, f);
    // Streaming with single-cycle memory, then a 5-cycle stall and release.
    repeat (20) step(1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1, f);
    repeat (5)  step(1'b1, 1'b1, 1'b1, 0, 32'd0, 1'b1, f);
    repeat (8)  step(1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1, f);
    // Redirect to a misaligned target with two fetches in flight.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b1, 1'b0, 1'b0, 3, 32'h0000_0102, 1'b1, f);
      hit = f;
    end
    if (!hit) miss_cnt++;
    repeat (12) step(1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1, f);
    // Redirect coinciding with an rvalid and a pop.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b1, 1'b1, 1'b0, 2, 32'h0000_4000, 1'b1, f);
      hit = f;
    end
    if (!hit) miss_cnt++;
    repeat (10) step(1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1, f);
    // Fetch PC wraps past the top of the address space.
    step(1'b1, 1'b1, 1'b0, 1, 32'hFFFF_FFF8, 1'b1, f);
    repeat (10) step(1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1, f);
    // Empty with stall held, then reset in mid-stream.
    repeat (3) step(1'b0, 1'b1, 1'b1, 0, 32'd0, 1'b1, f);
    repeat (3) step(1'b0, 1'b1, 1'b0, 0, 32'd0, 1'b1, f);
    repeat (4) step(1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1, f);
    step(1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b0, f);
    repeat (6) step(1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1, f);
    // Randomised traffic.
    spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
           ($urandom_range(0, 39) == 0) ? 1 : (($urandom_range(0, 59) == 0) ? 2 : 0),
           $urandom, $urandom_range(0, 299) != 0, f);
    end
    spurious_en = 1'b0;
    repeat (8) step(1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1, f);
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
